// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared definitions for the round-robin one-hot arbiter: FSM state encoding
// and the default hold limit used when the preemption build option is on.
package rr_onehot_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_e;

    localparam int ARB_MAX_HOLD_DEFAULT = 8;

endpackage

// File: rtl/rr_onehot_arbiter_rr_pick.sv
// Combinational circular priority picker. Returns the first set bit of req at
// or above the one-hot ptr position, wrapping around. A zero ptr is treated as
// bit 0 so the picker never stalls on a corrupted pointer.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] pick
);

    logic [N-1:0]   ptr_eff;
    logic [N-1:0]   mask_lo;
    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] req_lsb;

    // Double-width scan: the lower copy only exposes bits at/above ptr, the
    // upper copy supplies the wrap-around candidates, lowest set bit wins.
    always_comb begin
        ptr_eff = (ptr == '0) ? N'(1) : ptr;
        mask_lo = ~(ptr_eff - N'(1));
        req_dbl = {req, req & mask_lo};
        req_lsb = req_dbl & (~req_dbl + (2*N)'(1));
        pick    = req_lsb[N-1:0] | req_lsb[2*N-1:N];
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority ring and a registered
// one-hot grant. Ownership is held while the owner keeps req high.
// Build option ARB_PREEMPT_EN: revokes the grant after MAX_HOLD cycles when
// another requester is waiting; without it no hold counter exists.
module rr_onehot_arbiter
    import rr_onehot_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT,
    parameter int HOLD_W   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         grant,
    output logic                    grant_valid,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    busy
);

    localparam int IDX_W = $clog2(NREQ);

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0] pick;
    logic            release_now;

    rr_pick #(.N(NREQ)) u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick)
    );

`ifdef ARB_PREEMPT_EN
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              revoke;

    // Revoke once the owner has used its hold budget and someone else waits.
    always_comb begin
        revoke = (hold_q == HOLD_W'(MAX_HOLD - 1)) && ((req & ~grant_q) != '0);
    end
`endif

    // Next-state logic: grant on IDLE, release (or revoke) on OWN.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = (ptr_q == '0) ? NREQ'(1) : ptr_q;
        release_now = ((req & grant_q) == '0);
`ifdef ARB_PREEMPT_EN
        hold_d      = hold_q;
        release_now = release_now || revoke;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (req != '0) begin
                    grant_d = pick;
                    state_d = ARB_OWN;
`ifdef ARB_PREEMPT_EN
                    hold_d  = '0;
`endif
                end
            end
            ARB_OWN: begin
                if (release_now) begin
                    grant_d = '0;
                    state_d = ARB_IDLE;
                    ptr_d   = {grant_q[NREQ-2:0], grant_q[NREQ-1]};
                    if ({grant_q[NREQ-2:0], grant_q[NREQ-1]} == '0) begin
                        ptr_d = NREQ'(1);
                    end
                end
`ifdef ARB_PREEMPT_EN
                else if (hold_q != HOLD_W'(MAX_HOLD)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
`endif
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, grant and pointer registers; reset clears grant immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= NREQ'(1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_PREEMPT_EN
    // Consecutive-hold counter, saturating at MAX_HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    // Outputs decoded from the registered grant and state.
    always_comb begin
        grant       = grant_q;
        grant_valid = (grant_q != '0);
        busy        = (state_q == ARB_OWN);
        grant_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                grant_idx = grant_idx | IDX_W'(i);
            end
        end
    end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter (NREQ=4, MAX_HOLD=8).
// A behavioural index-based model predicts the outputs after every edge;
// predictions are queued when stimulus is driven and compared after the edge.
module tb_rr_onehot_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 8;

    typedef struct {
        logic [3:0] g;
        logic [1:0] idx;
        logic       v;
        logic       b;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       busy;

    int checks = 0;
    int errors = 0;

    exp_t sb_q[$];

    int m_own  = -1;
    int m_ptr  = 0;
    int m_hold = 0;
    int m_len  = 0;

    logic [3:0] seq[$];
    logic [3:0] prev_g;
    logic [3:0] exp_seq[5];

    rr_onehot_arbiter #(.NREQ(N), .MAX_HOLD(MAXH), .HOLD_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own  = -1;
        m_ptr  = 0;
        m_hold = 0;
        m_len  = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        logic rel;
        logic found;
        int   idx;
        if (m_own < 0) begin
            if (r != 4'b0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (!found && r[idx]) begin
                        m_own = idx;
                        found = 1'b1;
                    end
                end
                m_hold = 0;
                m_len  = 1;
            end
        end else begin
            rel = !r[m_own];
`ifdef ARB_PREEMPT_EN
            if (m_hold == MAXH - 1 && (r & ~(4'b0001 << m_own)) != 4'b0) rel = 1'b1;
`endif
            if (rel) begin
                m_ptr = (m_own + 1) % N;
                m_own = -1;
                m_len = 0;
            end else begin
                if (m_hold < MAXH) m_hold++;
                m_len++;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.g   = (m_own < 0) ? 4'b0 : (4'b0001 << m_own);
        e.idx = (m_own < 0) ? 2'd0 : 2'(m_own);
        e.v   = (m_own >= 0);
        e.b   = (m_own >= 0);
        return e;
    endfunction

    task automatic step(input logic [3:0] r, input logic rs);
        exp_t e;
        @(negedge clk);
        req   = r;
        reset = rs;
        if (rs) model_reset();
        else    model_step(r);
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("grant", 32'(grant), 32'(e.g));
        chk("grant_valid", 32'(grant_valid), 32'(e.v));
        chk("grant_idx", 32'(grant_idx), 32'(e.idx));
        chk("busy", 32'(busy), 32'(e.b));
        if (grant != 4'b0 && prev_g == 4'b0) seq.push_back(grant);
        prev_g = grant;
    endtask

    initial begin
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000;
        exp_seq[4] = 4'b0001;
        prev_g = 4'b0;
        reset  = 1'b1;
        req    = 4'b0;
        model_reset();
        #12;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_valid", 32'(grant_valid), 32'h0);
        chk("rst_idx", 32'(grant_idx), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Async reset mid-grant, then regrant one cycle after release.
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        chk("pre_rst_grant", 32'(grant), 32'h2);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_grant", 32'(grant), 32'h0);
        chk("async_rst_valid", 32'(grant_valid), 32'h0);
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b0);
        chk("post_rst_grant", 32'(grant), 32'h2);

        // Round-robin fairness: each owner drops req after 3 grant cycles.
        step(4'b0000, 1'b1);
        prev_g = 4'b0;
        seq.delete();
        for (int c = 0; c < 24; c++) begin
            logic [3:0] r;
            r = 4'b1111;
            if (m_own >= 0 && m_len == 3) r[m_own] = 1'b0;
            step(r, 1'b0);
        end
        chk("fair_len", 32'(seq.size() >= 5), 32'h1);
        for (int k = 0; k < 5; k++) begin
            if (k < seq.size()) chk("fair_order", 32'(seq[k]), 32'(exp_seq[k]));
        end

        // Wrap and sparse: owner 3 releases, only req[2] -> grant 0100, idx 2.
        step(4'b0000, 1'b1);
        step(4'b1000, 1'b0);
        chk("wrap_own3", 32'(grant), 32'h8);
        step(4'b0100, 1'b0);
        chk("wrap_dead", 32'(grant), 32'h0);
        step(4'b0100, 1'b0);
        chk("wrap_grant", 32'(grant), 32'h4);
        chk("wrap_idx", 32'(grant_idx), 32'h2);

        // Simultaneous release of owner 1 and rise of req[2].
        step(4'b0000, 1'b1);
        step(4'b0010, 1'b0);
        chk("sim_own1", 32'(grant), 32'h2);
        step(4'b0100, 1'b0);
        chk("sim_dead", 32'(grant), 32'h0);
        step(4'b0100, 1'b0);
        chk("sim_grant", 32'(grant), 32'h4);
        step(4'b0000, 1'b0);

        // Two requesters held constantly.
        step(4'b0000, 1'b1);
        step(4'b0011, 1'b0);
        chk("two_first", 32'(grant), 32'h1);
`ifdef ARB_PREEMPT_EN
        for (int c = 0; c < 7; c++) step(4'b0011, 1'b0);
        chk("pre_hold8", 32'(grant), 32'h1);
        step(4'b0011, 1'b0);
        chk("pre_revoke", 32'(grant), 32'h0);
        step(4'b0011, 1'b0);
        chk("pre_next", 32'(grant), 32'h2);
        for (int c = 0; c < 20; c++) step(4'b0011, 1'b0);
`else
        for (int c = 0; c < 55; c++) step(4'b0011, 1'b0);
        chk("nopre_hold", 32'(grant), 32'h1);
`endif

        // Lone owner never revoked.
        step(4'b0000, 1'b1);
        for (int c = 0; c < 25; c++) step(4'b0001, 1'b0);
        chk("lone_hold", 32'(grant), 32'h1);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
